pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Sequencer on the far side of the PLL's reset/locked interface. It drives the PLL reset, monitors the PLL lock output, and releases the core's system reset only after lock has been stable for a programmed time. It retries lock acquisition with a bounded retry count and reports loss of lock. It sits in the reference-clock domain next to the PLL instance, and its outputs gate every core reset.

## Interface
- RST_PULSE_CYCLES, 16: cycles PLL reset is held high per attempt (≥2).
- LOCK_TIMEOUT_CYCLES, 500000: cycles allowed for lock after PLL reset release (10 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive locked cycles required before system reset release.
- MAX_RETRIES, 3: extra PLL reset attempts after the first timeout before failing.

Ports:
- refclk  in  1  free-running reference clock (50 MHz); sole clock.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL lock, asynchronous to refclk.
- restart  in  1  single-cycle request to re-run the full sequence.
- pll_rst  out  1  active-high reset to PLL.
- sys_rst_n  out  1  active-low system reset for the core.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retries  out  $clog2(MAX_RETRIES+1)  retries used in the current sequence.
- lost_cnt  out  8  saturating count of lock losses seen in RUN.

## Operation
- pll_locked passes through a 2-flop synchronizer to give locked_s. All decisions use locked_s.
- One cycle counter is shared by all timed states and cleared on every state change.
- PLL_RST: pll_rst=1. After RST_PULSE_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK: pll_rst=0.
  - If locked_s=1, go to STABLE.
  - Else on counter = LOCK_TIMEOUT_CYCLES-1: if retries = MAX_RETRIES, go to FAIL; otherwise increment retries and go to PLL_RST.
- STABLE:
  - If locked_s=0, go to WAIT_LOCK. The timeout restarts and retries is unchanged.
  - On counter = STABLE_CYCLES-1, go to RUN.
- RUN: sys_rst_n=1, ready=1, retries cleared on entry.
  - If locked_s=0, increment lost_cnt (saturates at 255) and leave RUN (see Configuration).
- FAIL: pll_rst=0, fail=1, sys_rst_n=0. Held until restart.
- restart=1 in any state forces PLL_RST with retries cleared. restart has priority over all other transitions. lost_cnt is not cleared by restart.
- sys_rst_n=0 in every state except RUN.

## Timing
- Reset values: pll_rst=1, sys_rst_n=0, ready=0, fail=0, retries=0, lost_cnt=0, state=PLL_RST, counter=0.
- rst_n assertion mid-operation forces these values immediately (asynchronously). After release, a full RST_PULSE_CYCLES pulse follows.
- All outputs are registered and decoded from next-state, so they change on the same edge as the state register.
- pll_locked rising to sys_rst_n rising takes 2 (sync) + STABLE_CYCLES + 1 cycles, assuming lock stays high.
- pll_locked falling in RUN to sys_rst_n=0 takes 3 cycles.
- Counter width is $clog2 of the largest timing parameter. There is no wrap: each state exits before the counter reaches its terminal value+1.

## Configuration
- PLL_LOCK_SUPERVISOR_RELOCK_EN defined: loss of lock in RUN goes to PLL_RST, giving a full re-sequence with a PLL reset pulse.
- Undefined: loss of lock in RUN goes to WAIT_LOCK. pll_rst stays 0, and the normal timeout/retry path applies from there.

## Structure
- Shared package pll_sup_pkg holds:
  - state enum (PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL), 3 bits;
  - lost_cnt width constant (8).
- One sub-module, pll_sync2: 2-flop synchronizer with asynchronous active-low reset to 0. It is reusable elsewhere in the core.

## Test plan
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=64, STABLE_CYCLES=8, MAX_RETRIES=2.
- Normal bring-up: release rst_n and raise pll_locked 10 cycles after pll_rst falls.
  - pll_rst high exactly 4 cycles.
  - sys_rst_n and ready rise 11 cycles after pll_locked.
- Timeout/fail: pll_locked held 0.
  - Three PLL reset pulses, each followed by 64 cycles of waiting.
  - retries reaches 2, then fail=1 and sys_rst_n=0.
  - A restart pulse gives fail=0, retries=0, and a new 4-cycle pll_rst pulse.
- Glitchy lock: in STABLE, pll_locked drops for 1 cycle at count 5.
  - Returns to WAIT_LOCK; no sys_rst_n release until 8 clean cycles follow.
- Lock loss in RUN: drop pll_locked.
  - sys_rst_n=0 after 3 cycles, lost_cnt=1.
  - With RELOCK_EN, pll_rst pulses for 4 cycles; without it, pll_rst stays 0.
- rst_n asserted while in RUN: all outputs at reset values immediately, lost_cnt=0, and the sequence restarts after release.
- lost_cnt saturation: 300 lock losses leave lost_cnt=255.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int LOST_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to 0.
module pll_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer gating the core system reset.
// Define PLL_LOCK_SUPERVISOR_RELOCK_EN to re-pulse the PLL reset on loss of lock in RUN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                               refclk,
  input  logic                               rst_n,
  input  logic                               pll_locked,
  input  logic                               restart,
  output logic                               pll_rst,
  output logic                               sys_rst_n,
  output logic                               ready,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retries,
  output logic [LOST_W-1:0]                  lost_cnt
);

  localparam int CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RW      = $clog2(MAX_RETRIES+1);

  localparam logic [CW-1:0]     RST_LAST  = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0]     TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]     STB_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [LOST_W-1:0] LOST_MAX  = {LOST_W{1'b1}};

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     retries_q, retries_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic              locked_s;
  logic              cnt_clr;
  logic              timed;

  pll_sync2 u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    lost_d    = lost_q;
    cnt_clr   = 1'b0;
    if (restart) begin
      state_d   = PLL_RST;
      retries_d = '0;
      cnt_clr   = 1'b1;
    end else begin
      case (state_q)
        PLL_RST: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
          end else if (cnt_q == TMO_LAST) begin
            if (retries_q == RETRY_MAX) begin
              state_d = FAIL;
            end else begin
              retries_d = retries_q + RW'(1);
              state_d   = PLL_RST;
            end
          end
        end
        // A lock drop wins over the stable-count terminal so a glitch never releases reset.
        STABLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STB_LAST) begin
            state_d   = RUN;
            retries_d = '0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            if (lost_q != LOST_MAX) lost_d = lost_q + LOST_W'(1);
`ifdef PLL_LOCK_SUPERVISOR_RELOCK_EN
            state_d = PLL_RST;
`else
            state_d = WAIT_LOCK;
`endif
          end
        end
        FAIL: state_d = FAIL;
        default: state_d = PLL_RST;
      endcase
    end
    if (state_d != state_q) cnt_clr = 1'b1;
  end

  assign timed = (state_q == PLL_RST) || (state_q == WAIT_LOCK) || (state_q == STABLE);
  assign cnt_d = cnt_clr ? '0 : (timed ? cnt_q + CW'(1) : cnt_q);

  // Outputs are decoded from next-state so they move on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      retries_q <= '0;
      lost_q    <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      lost_q    <= lost_d;
      pll_rst   <= (state_d == PLL_RST);
      sys_rst_n <= (state_d == RUN);
      ready     <= (state_d == RUN);
      fail      <= (state_d == FAIL);
    end
  end

  assign retries  = retries_q;
  assign lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;

`ifdef PLL_LOCK_SUPERVISOR_RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [1:0] retries;
  logic [7:0] lost_cnt;

  int total = 0;
  int bad   = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (64),
    .STABLE_CYCLES       (8),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fail       (fail),
    .retries    (retries),
    .lost_cnt   (lost_cnt)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic       rst_n;
    logic       lk;
    logic       rs;
    int         n;
    logic       e_pll_rst;
    logic       e_sys;
    logic       e_rdy;
    logic       e_fail;
    logic [1:0] e_ret;
    logic [7:0] e_lost;
  } vec_t;

  vec_t tbl[23];
  int   nv = 0;

  task automatic add(input logic r, input logic lk, input logic rs, input int n,
                     input logic pr, input logic sy, input logic rd, input logic fl,
                     input logic [1:0] rt, input logic [7:0] lo);
    tbl[nv] = '{r, lk, rs, n, pr, sy, rd, fl, rt, lo};
    nv++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_for(input string name, input logic want, input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge refclk);
      if (ready == want) break;
    end
    if (k == limit) check({name, " timeout"}, 0, 1);
  endtask

  initial begin
    int hi;
    int rise;

    //  rst lk rs  n   prst sys rdy fail ret lost
    add(0, 0, 0,  2,  1,   0,  0,  0,   0,  0);   // reset state
    add(1, 0, 0,  3,  1,   0,  0,  0,   0,  0);   // pulse cnt 3
    add(1, 0, 0,  1,  0,   0,  0,  0,   0,  0);   // WAIT_LOCK
    add(1, 0, 0, 10,  0,   0,  0,  0,   0,  0);
    add(1, 1, 0, 10,  0,   0,  0,  0,   0,  0);   // 10 cycles after lock: still held
    add(1, 1, 0,  1,  0,   1,  1,  0,   0,  0);   // 11th: RUN
    add(1, 1, 0,  5,  0,   1,  1,  0,   0,  0);
    add(1, 0, 1,  1,  1,   0,  0,  0,   0,  0);   // restart beats lock loss
    add(1, 0, 0,  3,  1,   0,  0,  0,   0,  0);
    add(1, 0, 0,  1,  0,   0,  0,  0,   0,  0);
    add(1, 0, 0, 63,  0,   0,  0,  0,   0,  0);
    add(1, 0, 0,  1,  1,   0,  0,  0,   1,  0);   // first timeout
    add(1, 0, 0,  3,  1,   0,  0,  0,   1,  0);
    add(1, 0, 0,  1,  0,   0,  0,  0,   1,  0);
    add(1, 0, 0, 63,  0,   0,  0,  0,   1,  0);
    add(1, 0, 0,  1,  1,   0,  0,  0,   2,  0);   // second timeout
    add(1, 0, 0,  4,  0,   0,  0,  0,   2,  0);
    add(1, 0, 0, 63,  0,   0,  0,  0,   2,  0);
    add(1, 0, 0,  1,  0,   0,  0,  1,   2,  0);   // third timeout: FAIL
    add(1, 0, 0, 10,  0,   0,  0,  1,   2,  0);
    add(1, 0, 1,  1,  1,   0,  0,  0,   0,  0);   // restart out of FAIL
    add(1, 0, 0,  3,  1,   0,  0,  0,   0,  0);
    add(1, 0, 0,  1,  0,   0,  0,  0,   0,  0);

    rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    for (int i = 0; i < nv; i++) begin
      rst_n      = tbl[i].rst_n;
      pll_locked = tbl[i].lk;
      restart    = tbl[i].rs;
      repeat (tbl[i].n) @(negedge refclk);
      check($sformatf("v%0d pll_rst", i),   pll_rst,   tbl[i].e_pll_rst);
      check($sformatf("v%0d sys_rst_n", i), sys_rst_n, tbl[i].e_sys);
      check($sformatf("v%0d ready", i),     ready,     tbl[i].e_rdy);
      check($sformatf("v%0d fail", i),      fail,      tbl[i].e_fail);
      check($sformatf("v%0d retries", i),   retries,   tbl[i].e_ret);
      check($sformatf("v%0d lost_cnt", i),  lost_cnt,  tbl[i].e_lost);
    end

    // Glitchy lock: one-cycle drop while STABLE count is 5.
    pll_locked = 1'b1;
    repeat (3) @(negedge refclk);
    repeat (5) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    repeat (2) @(negedge refclk);
    check("glitch early release", sys_rst_n, 0);
    repeat (8) @(negedge refclk);
    check("glitch 7 clean", sys_rst_n, 0);
    @(negedge refclk);
    check("glitch 8 clean", sys_rst_n, 1);
    check("glitch ready", ready, 1);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    check("loss sys held", sys_rst_n, 1);
    @(negedge refclk);
    check("loss sys_rst_n", sys_rst_n, 0);
    check("loss ready", ready, 0);
    check("loss lost_cnt", lost_cnt, 1);
    hi = pll_rst ? 1 : 0;
    repeat (7) begin
      @(negedge refclk);
      if (pll_rst) hi++;
    end
    check("loss pll_rst cycles", hi, RELOCK ? 4 : 0);
    pll_locked = 1'b1;
    wait_for("relock", 1'b1, 60);

    // Asynchronous reset while in RUN.
    #1 rst_n = 1'b0;
    #1;
    check("arst pll_rst", pll_rst, 1);
    check("arst sys_rst_n", sys_rst_n, 0);
    check("arst ready", ready, 0);
    check("arst fail", fail, 0);
    check("arst retries", retries, 0);
    check("arst lost_cnt", lost_cnt, 0);
    @(negedge refclk);
    rst_n = 1'b1;
    #1;
    hi = pll_rst ? 1 : 0;
    rise = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge refclk);
      if (pll_rst) hi++;
      if (sys_rst_n) begin
        rise = k;
        break;
      end
    end
    check("arst pulse cycles", hi, 4);
    check("arst release cycle", rise, 13);

    // Saturation of the loss counter.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      wait_for("sat drop", 1'b0, 10);
      pll_locked = 1'b1;
      wait_for("sat relock", 1'b1, 60);
      if (i == 254) check("sat at 255 losses", lost_cnt, 255);
    end
    check("sat at 300 losses", lost_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
